cla_bist_checker: RTL and testbench
===================================

Name: cla_bist_checker

Overview:
- Synthesizable on-chip stimulus/response engine for the 4-bit carry-lookahead adder `carryadder`.
- Drives all 512 input combinations onto the adder's bit-level inputs and samples its s0..s3/c4 outputs.
- Compares each sample against an internally computed golden sum and reports pass/fail, error count and first failing pattern.
- Sits beside the adder in the top level; replaces simulation-only stimulus for silicon/FPGA self-test.

Parameters:
- SETTLE_CYCLES, 1, clock cycles each pattern is held before sampling (1..15).
- NUM_PATTERNS, 512, patterns per run; fixed by the 9 adder inputs and not to be overridden.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run when idle.
- c0, a0, b0, a1, b1, a2, b2, a3, b3  output  1 each  registered stimulus to adder inputs.
- s0, s1, s2, s3, c4  input  1 each  adder response.
- busy  output  1  run in progress.
- done  output  1  level; set at run end, cleared by next accepted start.
- pass  output  1  done and zero errors.
- err_count  output  10  mismatching patterns this run (0..512).
- fail_valid  output  1  at least one mismatch captured.
- first_fail  output  9  pattern index of first mismatch.

Behaviour:
- Reset (async assert, sync release): all stimulus outputs 0; busy, done, pass, fail_valid 0; err_count 0; first_fail 0; FSM to IDLE.
- Pattern index p[8:0] maps to stimulus as: bit0=a0, bit1=b0, bit2=a1, bit3=b1, bit4=a2, bit5=b2, bit6=a3, bit7=b3, bit8=c0. c0 is the slowest-changing input.
- A = {a3,a2,a1,a0}; B = {b3,b2,b1,b0}; expected = A + B + c0, 5-bit. Observed = {c4,s3,s2,s1,s0}.
- FSM states:
  - IDLE: stimulus held at 0. On start: clear err_count, fail_valid, first_fail, done and pass; set p=0 and busy=1; go to APPLY.
  - APPLY: stimulus registers equal p. Hold for SETTLE_CYCLES cycles using a settle counter, then go to SAMPLE.
  - SAMPLE: one cycle; compare observed with expected(p).
    - On mismatch: increment err_count; if fail_valid=0, capture first_fail=p and set fail_valid.
    - If p=511, go to DONE; otherwise increment p and return to APPLY.
  - DONE: one cycle; busy=0, done=1, pass=(err_count==0). Stimulus returns to 0. Go to IDLE.
- Run length from start accepted to done high: 512*(SETTLE_CYCLES+1)+2 cycles (1026 cycles for the default SETTLE_CYCLES=1).
- Pattern counter never wraps mid-run; err_count cannot overflow (maximum 512 fits in 10 bits).
- start while busy: ignored, with no effect on counters.
- start in the same cycle as DONE: ignored; a new run needs start in IDLE.
- Reset mid-run: immediate return to reset values; no partial results retained.
- s*/c4 are sampled only in SAMPLE; they are don't-care elsewhere.

Decomposition:
- Package cla_bist_pkg holds:
  - FSM state enum (IDLE, APPLY, SAMPLE, DONE).
  - PAT_W=9, ERR_W=10, NUM_PATTERNS=512.
  - The pattern-to-input bit mapping constants.
- One sub-module, cla_golden_model: purely combinational, p[8:0] -> expected[4:0]. It is reusable by the testbench scoreboard.

Test Plan:
- Golden adder connected, SETTLE_CYCLES=1, start pulse -> done=1 after 1026 cycles; pass=1, err_count=0, fail_valid=0.
- c4 forced to 0 -> err_count=256, fail_valid=1, first_fail=87 (A=15, B=1, c0=0), pass=0.
- s0 inverted -> err_count=512, first_fail=0, pass=0.
- rst asserted at cycle 100 of a run -> all outputs at reset values that cycle; fresh start then completes with pass=1.
- start pulsed again at cycle 50 of a run -> ignored; run completes at the original cycle with unchanged results.
- SETTLE_CYCLES=3, adder with 2-cycle registered output delay -> pass=1; same delayed adder with SETTLE_CYCLES=1 -> pass=0.

Source files
------------

// File: rtl/cla_bist_pkg.sv
// Shared constants, FSM state encoding and stimulus bit mapping for the
// carry-lookahead adder self-test engine.
package cla_bist_pkg;

    localparam int unsigned PAT_W        = 9;
    localparam int unsigned ERR_W        = 10;
    localparam int unsigned SUM_W        = 5;
    localparam int unsigned SETTLE_W     = 4;
    localparam int unsigned NUM_PATTERNS = 512;

    // Pattern index bit positions; c0 is the MSB so it changes slowest.
    localparam int unsigned BIT_A0 = 0;
    localparam int unsigned BIT_B0 = 1;
    localparam int unsigned BIT_A1 = 2;
    localparam int unsigned BIT_B1 = 3;
    localparam int unsigned BIT_A2 = 4;
    localparam int unsigned BIT_B2 = 5;
    localparam int unsigned BIT_A3 = 6;
    localparam int unsigned BIT_B3 = 7;
    localparam int unsigned BIT_C0 = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    // Field order matches the BIT_* positions so a pattern casts straight in.
    typedef struct packed {
        logic c0;
        logic b3;
        logic a3;
        logic b2;
        logic a2;
        logic b1;
        logic a1;
        logic b0;
        logic a0;
    } stim_t;

endpackage

// File: rtl/cla_golden_model.sv
// Combinational reference for the 4-bit adder: pattern index -> {c4,s3..s0}.
module cla_golden_model
    import cla_bist_pkg::*;
(
    input  logic [PAT_W-1:0] pat,
    output logic [SUM_W-1:0] expected_c
);

    logic [3:0] a_v;
    logic [3:0] b_v;

    always_comb begin
        a_v = {pat[BIT_A3], pat[BIT_A2], pat[BIT_A1], pat[BIT_A0]};
        b_v = {pat[BIT_B3], pat[BIT_B2], pat[BIT_B1], pat[BIT_B0]};
        expected_c = SUM_W'(a_v) + SUM_W'(b_v) + SUM_W'(pat[BIT_C0]);
    end

endmodule

// File: rtl/cla_bist_checker.sv
// Exhaustive stimulus/response self-test engine for the 4-bit carry-lookahead
// adder: walks all 512 input patterns, compares against a golden sum.
module cla_bist_checker
    import cla_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             c0,
    output logic             a0,
    output logic             b0,
    output logic             a1,
    output logic             b1,
    output logic             a2,
    output logic             b2,
    output logic             a3,
    output logic             b3,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             s3,
    input  logic             c4,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [PAT_W-1:0] first_fail
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [PAT_W-1:0]    PAT_LAST    = PAT_W'(NUM_PATTERNS - 1);

    state_e             state_q,      state_d;
    logic [PAT_W-1:0]   pat_q,        pat_d;
    logic [SETTLE_W-1:0] settle_q,    settle_d;
    logic [ERR_W-1:0]   err_count_q,  err_count_d;
    logic               fail_valid_q, fail_valid_d;
    logic [PAT_W-1:0]   first_fail_q, first_fail_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic               pass_q,       pass_d;
    stim_t              stim_q,       stim_d;

    logic [SUM_W-1:0]   expected_c;
    logic [SUM_W-1:0]   observed_c;

    cla_golden_model u_golden (
        .pat        (pat_q),
        .expected_c (expected_c)
    );

    assign observed_c = {c4, s3, s2, s1, s0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pat_q        <= '0;
            settle_q     <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            stim_q       <= '0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            settle_q     <= settle_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            stim_q       <= stim_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        settle_d     = settle_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    pat_d        = '0;
                    settle_d     = '0;
                    busy_d       = 1'b1;
                    state_d      = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (observed_c != expected_c) begin
                    err_count_d = err_count_q + ERR_W'(1);
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        first_fail_d = pat_q;
                    end
                end
                if (pat_q == PAT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    pat_d   = pat_q + PAT_W'(1);
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_count_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stimulus tracks the next pattern so it lands together with the state.
        stim_d = '0;
        if (state_d == ST_APPLY || state_d == ST_SAMPLE) begin
            stim_d = stim_t'(pat_d);
        end
    end

    assign c0         = stim_q.c0;
    assign a0         = stim_q.a0;
    assign b0         = stim_q.b0;
    assign a1         = stim_q.a1;
    assign b1         = stim_q.b1;
    assign a2         = stim_q.a2;
    assign b2         = stim_q.b2;
    assign a3         = stim_q.a3;
    assign b3         = stim_q.b3;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_cla_bist_checker.sv
// Directed bench for cla_bist_checker with a behavioural adder that can be
// faulted (c4 stuck-0, s0 inverted) or delayed by two registered stages.
`timescale 1ns/1ps
module tb_cla_bist_checker;

    logic clk;
    logic rst;
    logic start;
    logic start3;
    int   mode;
    int   n_tests;
    int   n_fail;
    int   lat;

    wire  [8:0] st1;
    wire  [8:0] st3;
    logic [4:0] rsp1;
    logic [4:0] rsp3;
    logic [4:0] d1a, d2a, d1b, d2b;

    wire        busy, done, pass, fail_valid;
    wire  [9:0] err_count;
    wire  [8:0] first_fail;
    wire        busy3, done3, pass3, fail_valid3;
    wire  [9:0] err_count3;
    wire  [8:0] first_fail3;

    cla_bist_checker dut (
        .clk(clk), .rst(rst), .start(start),
        .a0(st1[0]), .b0(st1[1]), .a1(st1[2]), .b1(st1[3]),
        .a2(st1[4]), .b2(st1[5]), .a3(st1[6]), .b3(st1[7]), .c0(st1[8]),
        .s0(rsp1[0]), .s1(rsp1[1]), .s2(rsp1[2]), .s3(rsp1[3]), .c4(rsp1[4]),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail(first_fail)
    );

    cla_bist_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .a0(st3[0]), .b0(st3[1]), .a1(st3[2]), .b1(st3[3]),
        .a2(st3[4]), .b2(st3[5]), .a3(st3[6]), .b3(st3[7]), .c0(st3[8]),
        .s0(rsp3[0]), .s1(rsp3[1]), .s2(rsp3[2]), .s3(rsp3[3]), .c4(rsp3[4]),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
        .fail_valid(fail_valid3), .first_fail(first_fail3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] adder(input logic [8:0] st);
        logic [3:0] a;
        logic [3:0] b;
        a = {st[6], st[4], st[2], st[0]};
        b = {st[7], st[5], st[3], st[1]};
        return 5'(a) + 5'(b) + 5'(st[8]);
    endfunction

    function automatic logic [4:0] inject(input logic [4:0] v, input int m);
        logic [4:0] r;
        r = v;
        if (m == 1) r[4] = 1'b0;
        if (m == 2) r[0] = ~r[0];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        d1a <= adder(st1);
        d2a <= d1a;
        d1b <= adder(st3);
        d2b <= d1b;
    end

    always_comb begin
        rsp1 = (mode == 3) ? d2a : inject(adder(st1), mode);
        rsp3 = (mode == 3) ? d2b : inject(adder(st3), mode);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_pass"},  32'(pass), 0);
        chk({tag, "_err"},   32'(err_count), 0);
        chk({tag, "_fv"},    32'(fail_valid), 0);
        chk({tag, "_ff"},    32'(first_fail), 0);
        chk({tag, "_stim"},  32'(st1), 0);
    endtask

    // inj: 0 none, 1 extra start pulse at cycle inj_at, 2 reset at cycle inj_at
    task automatic run(input bit use3, input int inj, input int inj_at, output int n);
        n = 0;
        @(negedge clk);
        if (use3) start3 = 1'b1;
        else      start  = 1'b1;
        while (n < 6000) begin
            @(posedge clk);
            #1;
            n++;
            start  = 1'b0;
            start3 = 1'b0;
            if (!use3 && n == 1) chk("done_cleared_on_start", 32'(done), 0);
            if (!use3 && n == 3) chk("stim_p1", 32'(st1), 1);
            if (!use3 && n == 10) chk("busy_mid_run", 32'(busy), 1);
            if (!use3 && n == 175) chk("stim_p87", 32'(st1), 87);
            if (!use3 && inj == 1 && n == inj_at) start = 1'b1;
            if (inj == 2 && n == inj_at) begin
                rst = 1'b1;
                #1;
                chk_reset_outputs("midrun_rst");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (use3 ? done3 : done) break;
        end
        if (n >= 6000) chk("run_timeout", 32'(n), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mode    = 0;
        rst     = 1'b1;
        start   = 1'b0;
        start3  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        chk("reset_busy3", 32'(busy3), 0);
        chk("reset_done3", 32'(done3), 0);
        @(negedge clk);
        rst = 1'b0;

        // Healthy adder
        run(1'b0, 0, 0, lat);
        chk("golden_latency", 32'(lat), 1026);
        chk("golden_pass", 32'(pass), 1);
        chk("golden_err", 32'(err_count), 0);
        chk("golden_fv", 32'(fail_valid), 0);
        chk("golden_busy_end", 32'(busy), 0);
        chk("golden_stim_end", 32'(st1), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_level_held", 32'(done), 1);

        // c4 stuck at 0
        mode = 1;
        run(1'b0, 0, 0, lat);
        chk("c4_latency", 32'(lat), 1026);
        chk("c4_err", 32'(err_count), 256);
        chk("c4_fv", 32'(fail_valid), 1);
        chk("c4_first", 32'(first_fail), 87);
        chk("c4_pass", 32'(pass), 0);
        chk("c4_done", 32'(done), 1);

        // s0 inverted
        mode = 2;
        run(1'b0, 0, 0, lat);
        chk("s0_err", 32'(err_count), 512);
        chk("s0_first", 32'(first_fail), 0);
        chk("s0_fv", 32'(fail_valid), 1);
        chk("s0_pass", 32'(pass), 0);

        // Reset at cycle 100, then a fresh run
        mode = 0;
        run(1'b0, 2, 100, lat);
        run(1'b0, 0, 0, lat);
        chk("after_rst_latency", 32'(lat), 1026);
        chk("after_rst_pass", 32'(pass), 1);
        chk("after_rst_err", 32'(err_count), 0);

        // Second start mid-run is ignored
        mode = 1;
        run(1'b0, 1, 50, lat);
        chk("restart_latency", 32'(lat), 1026);
        chk("restart_err", 32'(err_count), 256);
        chk("restart_first", 32'(first_fail), 87);
        @(posedge clk);
        #1;
        chk("restart_idle_busy", 32'(busy), 0);

        // Two-cycle delayed adder
        mode = 3;
        run(1'b1, 0, 0, lat);
        chk("dly_s3_latency", 32'(lat), 2050);
        chk("dly_s3_pass", 32'(pass3), 1);
        chk("dly_s3_err", 32'(err_count3), 0);
        chk("dly_s3_fv", 32'(fail_valid3), 0);
        run(1'b0, 0, 0, lat);
        chk("dly_s1_pass", 32'(pass), 0);
        chk("dly_s1_fv", 32'(fail_valid), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
